// File: rtl/cover_toggle_collector.sv
// Toggle-coverage collector: pends per-point hits and reports each pending point's global index through a ready/valid slot.
// Optional macro COVER_TOGGLE_DEDUP_EN limits reports to one per point per clear epoch.
module cover_toggle_collector #(
  parameter int WIDTH       = 2,
  parameter int COVER_INDEX = 0,
  parameter int COVER_TOTAL = 8065
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] valid,
  input  logic             clear,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_index,
  output logic [31:0]      report_count,
  output logic [31:0]      merge_count
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] pending;
  logic [WIDTH-1:0] sel_mask;
  logic [WIDTH-1:0] load_mask;
  logic [WIDTH-1:0] blocked;
  logic [WIDTH-1:0] live;
  logic [WIDTH-1:0] merge_mask;
  logic [63:0]      sel_index;
  logic [CNT_W-1:0] merge_inc;
  logic             handshake;
  logic             load_en;

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
  endfunction

`ifndef SYNTHESIS
  if (COVER_INDEX + WIDTH > COVER_TOTAL) begin : g_range_err
    $error("cover_toggle_collector: COVER_INDEX + WIDTH exceeds COVER_TOTAL");
  end
`endif

  // Descending scan so the lowest-numbered pending point wins.
  always_comb begin
    sel_mask  = '0;
    sel_index = 64'(COVER_INDEX);
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (pending[i]) begin
        sel_mask    = '0;
        sel_mask[i] = 1'b1;
        sel_index   = 64'(COVER_INDEX) + 64'(i);
      end
    end
  end

  assign handshake = out_valid && out_ready;
  assign load_en   = (!out_valid || handshake) && (|pending);
  assign load_mask = load_en ? sel_mask : '0;

`ifdef COVER_TOGGLE_DEDUP_EN
  logic [WIDTH-1:0] reported;

  // A hit arriving while its point is being loaded already belongs to this epoch's report.
  assign blocked = reported | load_mask;

  always_ff @(posedge clock) begin
    if (reset || clear) reported <= '0;
    else                reported <= reported | load_mask;
  end
`else
  assign blocked = '0;
`endif

  // Hits in a clear cycle are discarded outright, so they neither pend nor merge.
  assign live       = clear ? '0 : (valid & ~blocked);
  assign merge_mask = live & pending & ~load_mask;

  always_comb begin
    merge_inc = '0;
    for (int i = 0; i < WIDTH; i++) merge_inc = merge_inc + CNT_W'(merge_mask[i]);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pending      <= '0;
      out_valid    <= 1'b0;
      out_index    <= '0;
      report_count <= '0;
      merge_count  <= '0;
    end else begin
      pending <= clear ? '0 : ((pending & ~load_mask) | live);
      if (load_en) begin
        out_valid <= 1'b1;
        out_index <= sel_index;
      end else if (handshake) begin
        out_valid <= 1'b0;
      end
      if (handshake) report_count <= sat_add(report_count, 32'd1);
      merge_count <= sat_add(merge_count, 32'(merge_inc));
    end
  end

endmodule

// File: tb/tb_cover_toggle_collector.sv
// Scoreboard bench for cover_toggle_collector (WIDTH=2, COVER_INDEX=100); expectations follow COVER_TOGGLE_DEDUP_EN when defined.
module tb_cover_toggle_collector;

  logic        clock;
  logic        reset;
  logic [1:0]  valid;
  logic        clear;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_index;
  logic [31:0] report_count;
  logic [31:0] merge_count;

  int unsigned compared   = 0;
  int unsigned mismatched = 0;
  logic [63:0] exp_q[$];
  logic [31:0] exp_reports;
  logic [31:0] exp_merge;

  cover_toggle_collector #(
    .WIDTH(2),
    .COVER_INDEX(100),
    .COVER_TOTAL(8065)
  ) dut (
    .clock(clock),
    .reset(reset),
    .valid(valid),
    .clear(clear),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_index(out_index),
    .report_count(report_count),
    .merge_count(merge_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Every handshake pops the scoreboard; inputs are stable mid-cycle.
  always @(negedge clock) begin
    logic [63:0] exp_idx;
    if (!reset && out_valid && out_ready) begin
      compared++;
      if (exp_q.size() == 0) begin
        mismatched++;
        $display("FAIL unexpected_report: got index %0d, expected no report", out_index);
      end else begin
        exp_idx = exp_q.pop_front();
        if (out_index !== exp_idx) begin
          mismatched++;
          $display("FAIL report_index: got %0d expected %0d", out_index, exp_idx);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_pulse();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; valid = '0; clear = 1'b0; out_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;
    exp_reports = 0; exp_merge = 0;
    compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL reset_out_valid: got %0b expected 0", out_valid); end
    compared++; if (out_index !== 64'd0) begin mismatched++; $display("FAIL reset_out_index: got %0d expected 0", out_index); end
    compared++; if (report_count !== 32'd0) begin mismatched++; $display("FAIL reset_report_count: got %0d expected 0", report_count); end
    compared++; if (merge_count !== 32'd0) begin mismatched++; $display("FAIL reset_merge_count: got %0d expected 0", merge_count); end
  endtask

  task automatic test_single_hit();
    out_ready = 1'b1;
    valid = 2'b01;
    exp_q.push_back(64'd100); exp_reports++;
    tick();
    valid = 2'b00;
    compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL single_latency_early: got out_valid %0b expected 0", out_valid); end
    tick();
    compared++; if (out_valid !== 1'b1) begin mismatched++; $display("FAIL single_latency: got out_valid %0b expected 1", out_valid); end
    compared++; if (out_index !== 64'd100) begin mismatched++; $display("FAIL single_index: got %0d expected 100", out_index); end
    tick();
    compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL single_drop: got out_valid %0b expected 0", out_valid); end
    compared++; if (report_count !== exp_reports) begin mismatched++; $display("FAIL single_report_count: got %0d expected %0d", report_count, exp_reports); end
  endtask

  task automatic test_ordering();
    clear_pulse();
    out_ready = 1'b1;
    valid = 2'b11;
    exp_q.push_back(64'd100); exp_q.push_back(64'd101); exp_reports += 2;
    tick();
    valid = 2'b00;
    tick();
    compared++; if (out_index !== 64'd100 || out_valid !== 1'b1) begin mismatched++; $display("FAIL order_first: got valid %0b index %0d expected valid 1 index 100", out_valid, out_index); end
    tick();
    compared++; if (out_index !== 64'd101 || out_valid !== 1'b1) begin mismatched++; $display("FAIL order_second: got valid %0b index %0d expected valid 1 index 101", out_valid, out_index); end
    tick();
    compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL order_drop: got out_valid %0b expected 0", out_valid); end
    compared++; if (report_count !== exp_reports) begin mismatched++; $display("FAIL order_report_count: got %0d expected %0d", report_count, exp_reports); end
  endtask

  task automatic test_backpressure_merge();
    clear_pulse();
    out_ready = 1'b0;
    valid = 2'b10;
    exp_q.push_back(64'd101); exp_reports++;
`ifdef COVER_TOGGLE_DEDUP_EN
    exp_merge += 0;
`else
    // The hit landing on the load cycle re-pends point 1 and yields a second report later.
    exp_merge += 3;
    exp_q.push_back(64'd101); exp_reports++;
`endif
    tick();
    for (int c = 0; c < 4; c++) begin
      tick();
      compared++;
      if (out_valid !== 1'b1 || out_index !== 64'd101) begin
        mismatched++;
        $display("FAIL bp_stable_%0d: got valid %0b index %0d expected valid 1 index 101", c, out_valid, out_index);
      end
    end
    valid = 2'b00;
    compared++; if (merge_count !== exp_merge) begin mismatched++; $display("FAIL bp_merge_count: got %0d expected %0d", merge_count, exp_merge); end
    out_ready = 1'b1;
    tick(); tick(); tick();
    compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL bp_drop: got out_valid %0b expected 0", out_valid); end
    compared++; if (report_count !== exp_reports) begin mismatched++; $display("FAIL bp_report_count: got %0d expected %0d", report_count, exp_reports); end
  endtask

  task automatic test_dedup();
    int n;
`ifdef COVER_TOGGLE_DEDUP_EN
    n = 1;
`else
    n = 10;
`endif
    clear_pulse();
    out_ready = 1'b1;
    for (int k = 0; k < n; k++) exp_q.push_back(64'd100);
    exp_reports += n;
    valid = 2'b01;
    for (int c = 0; c < 10; c++) tick();
    valid = 2'b00;
    for (int c = 0; c < 4; c++) tick();
    compared++; if (exp_q.size() != 0) begin mismatched++; $display("FAIL dedup_outstanding: got %0d reports missing expected 0", exp_q.size()); end
    compared++; if (report_count !== exp_reports) begin mismatched++; $display("FAIL dedup_report_count: got %0d expected %0d", report_count, exp_reports); end
    compared++; if (merge_count !== exp_merge) begin mismatched++; $display("FAIL dedup_merge_count: got %0d expected %0d", merge_count, exp_merge); end
    clear_pulse();
    valid = 2'b01;
    exp_q.push_back(64'd100); exp_reports++;
    tick();
    valid = 2'b00;
    for (int c = 0; c < 4; c++) tick();
    compared++; if (report_count !== exp_reports) begin mismatched++; $display("FAIL dedup_after_clear: got %0d expected %0d", report_count, exp_reports); end
  endtask

  task automatic test_reset_mid();
    clear_pulse();
    out_ready = 1'b0;
    valid = 2'b11;
    tick();
    valid = 2'b00;
    tick();
    compared++; if (out_valid !== 1'b1) begin mismatched++; $display("FAIL rmid_setup: got out_valid %0b expected 1", out_valid); end
    reset = 1'b1; out_ready = 1'b1; valid = 2'b11;
    tick();
    reset = 1'b0; valid = 2'b00;
    exp_reports = 0; exp_merge = 0;
    compared++; if (out_valid !== 1'b0 || out_index !== 64'd0) begin mismatched++; $display("FAIL rmid_slot: got valid %0b index %0d expected 0/0", out_valid, out_index); end
    compared++; if (report_count !== 32'd0 || merge_count !== 32'd0) begin mismatched++; $display("FAIL rmid_counts: got %0d/%0d expected 0/0", report_count, merge_count); end
    for (int c = 0; c < 4; c++) tick();
    compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL rmid_stale: got out_valid %0b expected 0", out_valid); end
  endtask

  task automatic test_clear_priority();
    out_ready = 1'b1;
    valid = 2'b01;
    tick();
    clear = 1'b1; valid = 2'b10;
    exp_q.push_back(64'd100); exp_reports++;
    tick();
    clear = 1'b0; valid = 2'b00;
    compared++; if (out_valid !== 1'b1 || out_index !== 64'd100) begin mismatched++; $display("FAIL clr_load: got valid %0b index %0d expected valid 1 index 100", out_valid, out_index); end
    tick(); tick();
    compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL clr_discard: got out_valid %0b expected 0", out_valid); end
    compared++; if (report_count !== exp_reports) begin mismatched++; $display("FAIL clr_report_count: got %0d expected %0d", report_count, exp_reports); end
    compared++; if (exp_q.size() != 0) begin mismatched++; $display("FAIL final_outstanding: got %0d reports missing expected 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_single_hit();
    test_ordering();
    test_backpressure_merge();
    test_dedup();
    test_reset_mid();
    test_clear_priority();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
